// File: rtl/tcm_boot_loader.sv
// Boot loader: copies a program image from SPI NOR flash (READ 0x03, mode 0)
// into the SCR1 TCM, holding the core in reset until the last word is written.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// CMD   | shifting out READ opcode and 24-bit flash address
// DATA  | shifting in one 32-bit image word
// WRITE | word presented to TCM, SCK paused, CS kept low
// DONE  | image loaded, core released
module tcm_boot_loader #(
    parameter int          TCM_AW     = 14,
    parameter int          BOOT_WORDS = 1024,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          SCK_DIV    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              spi_sck_o,
    output logic              spi_cs_n_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic              tcm_we_o,
    output logic [TCM_AW-1:0] tcm_addr_o,
    output logic [31:0]       tcm_wdata_o,
    input  logic              tcm_ready_i,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int                DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
    localparam logic [TCM_AW-1:0] LAST_WORD = TCM_AW'(BOOT_WORDS - 1);
    localparam logic [31:0]       READ_CMD  = {8'h03, FLASH_BASE};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic              sck;
    logic [4:0]        bit_cnt;
    logic [31:0]       tx_sr;
    logic [31:0]       rx_sr;
    logic [TCM_AW-1:0] word_cnt;

    logic shifting;
    logic div_wrap;
    logic sck_rise;
    logic sck_fall;
    logic last_bit;
    logic start_load;
    logic accept;

    always_comb begin
        shifting   = (state == ST_CMD) || (state == ST_DATA);
        div_wrap   = shifting && (div_cnt == DIV_LAST);
        sck_rise   = div_wrap && !sck;
        sck_fall   = div_wrap && sck;
        last_bit   = sck_fall && (bit_cnt == 5'd0);
        start_load = start_i && ((state == ST_IDLE) || (state == ST_DONE));
        accept     = (state == ST_WRITE) && tcm_ready_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        spi_cs_n_o = 1'b1;
        spi_mosi_o = 1'b0;
        tcm_we_o   = 1'b0;
        core_rst_o = 1'b1;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_load) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                spi_cs_n_o = 1'b0;
                spi_mosi_o = tx_sr[31];
                busy_o     = 1'b1;
                if (last_bit) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                spi_cs_n_o = 1'b0;
                busy_o     = 1'b1;
                if (last_bit) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                spi_cs_n_o = 1'b0;
                tcm_we_o   = 1'b1;
                busy_o     = 1'b1;
                if (accept) state_nxt = (word_cnt == LAST_WORD) ? ST_DONE : ST_DATA;
            end
            ST_DONE: begin
                core_rst_o = 1'b0;
                done_o     = 1'b1;
                if (start_load) state_nxt = ST_CMD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bit counter is a 5-bit down-counter; it wraps 0 -> 31 on the last
    // falling edge, so it is already primed for the next 32-bit phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt     <= '0;
            sck         <= 1'b0;
            bit_cnt     <= 5'd31;
            tx_sr       <= '0;
            rx_sr       <= '0;
            word_cnt    <= '0;
            tcm_wdata_o <= '0;
        end else if (start_load) begin
            div_cnt  <= '0;
            sck      <= 1'b0;
            bit_cnt  <= 5'd31;
            tx_sr    <= READ_CMD;
            rx_sr    <= '0;
            word_cnt <= '0;
        end else if (shifting) begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) sck <= ~sck;
            if (sck_rise) rx_sr <= {rx_sr[30:0], spi_miso_i};
            if (sck_fall) begin
                tx_sr   <= {tx_sr[30:0], 1'b0};
                bit_cnt <= bit_cnt - 5'd1;
            end
            // Flash bytes arrive MSB first; the first byte lands in the low lane.
            if (last_bit && (state == ST_DATA)) begin
                tcm_wdata_o <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
            end
        end else if (accept && (word_cnt != LAST_WORD)) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    assign spi_sck_o  = sck;
    assign tcm_addr_o = word_cnt;

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Directed bench for tcm_boot_loader: a mode-0 SPI NOR model and a TCM
// recorder per instance, with per-scenario tasks checking hand-computed values.
module tb_tcm_boot_loader;

    logic clk;
    logic rst;
    logic mon_clr;
    logic [7:0] a_off;
    int checks;
    int errors;

    logic        a_start, a_sck, a_cs_n, a_mosi, a_miso, a_we, a_ready;
    logic        a_core_rst, a_busy, a_done;
    logic [3:0]  a_addr;
    logic [31:0] a_wdata;

    logic        b_start, b_sck, b_cs_n, b_mosi, b_miso, b_we, b_ready;
    logic        b_core_rst, b_busy, b_done;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;

    tcm_boot_loader #(.TCM_AW(4), .BOOT_WORDS(4), .FLASH_BASE(24'h000000), .SCK_DIV(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(a_start),
        .spi_sck_o(a_sck), .spi_cs_n_o(a_cs_n), .spi_mosi_o(a_mosi), .spi_miso_i(a_miso),
        .tcm_we_o(a_we), .tcm_addr_o(a_addr), .tcm_wdata_o(a_wdata), .tcm_ready_i(a_ready),
        .core_rst_o(a_core_rst), .busy_o(a_busy), .done_o(a_done)
    );

    tcm_boot_loader #(.TCM_AW(2), .BOOT_WORDS(1), .FLASH_BASE(24'h012340), .SCK_DIV(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start),
        .spi_sck_o(b_sck), .spi_cs_n_o(b_cs_n), .spi_mosi_o(b_mosi), .spi_miso_i(b_miso),
        .tcm_we_o(b_we), .tcm_addr_o(b_addr), .tcm_wdata_o(b_wdata), .tcm_ready_i(b_ready),
        .core_rst_o(b_core_rst), .busy_o(b_busy), .done_o(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: flash model, SCK timing and TCM recorder
    int          a_fr, a_rises, a_run, a_hi_min, a_hi_max, a_lo_min, a_lo_max;
    int          a_cmd_cyc, a_busy_cyc, a_rst_bad, a_wr_total, a_we_run, a_max_we_run, a_unstable;
    logic [31:0] a_cmd, a_hold_data;
    logic [3:0]  a_first_addr, a_hold_addr;
    logic        a_first_mosi, a_sck_q, a_cs_q, a_we_q;
    logic [31:0] a_mem [0:3];
    int          a_wr [0:3];
    int          a_k;
    logic [7:0]  a_bv;

    always @(negedge clk) begin
        if (mon_clr) begin
            a_fr = 0; a_rises = 0; a_run = 0; a_cmd = 0;
            a_hi_min = 1000; a_hi_max = 0; a_lo_min = 1000; a_lo_max = 0;
            a_cmd_cyc = 0; a_busy_cyc = 0; a_rst_bad = 0; a_wr_total = 0;
            a_we_run = 0; a_max_we_run = 0; a_unstable = 0;
            a_first_mosi = 1'b1; a_first_addr = 4'hF; a_hold_addr = 0; a_hold_data = 0;
            for (int i = 0; i < 4; i++) begin
                a_mem[i] = 32'hDEADBEEF;
                a_wr[i]  = 0;
            end
        end else begin
            if (a_cs_n) begin
                a_fr = 0; a_run = 0; a_miso = 1'b0;
            end else begin
                if (a_cs_q) a_first_mosi = a_mosi;
                if (a_sck && !a_sck_q) begin
                    if (a_fr < 32) a_cmd = {a_cmd[30:0], a_mosi};
                    a_fr++;
                    a_rises++;
                end
                if (!a_sck && a_sck_q && a_fr >= 32) begin
                    a_k    = a_fr - 32;
                    a_bv   = 8'(a_k / 8) + a_off;
                    a_miso = a_bv[7 - (a_k % 8)];
                end
                if (a_sck != a_sck_q) begin
                    if (a_run > 0) begin
                        if (a_sck_q) begin
                            if (a_run < a_hi_min) a_hi_min = a_run;
                            if (a_run > a_hi_max) a_hi_max = a_run;
                        end else begin
                            if (a_run < a_lo_min) a_lo_min = a_run;
                            if (a_run > a_lo_max) a_lo_max = a_run;
                        end
                    end
                    a_run = 0;
                end
                if (!a_we) a_run++;
                if (a_fr < 32 || (a_fr == 32 && a_sck)) a_cmd_cyc++;
            end
            if (a_busy) a_busy_cyc++;
            if (a_core_rst == a_done) a_rst_bad++;
            if (a_we) begin
                if (!a_we_q) begin
                    a_hold_addr = a_addr; a_hold_data = a_wdata; a_we_run = 1;
                end else begin
                    a_we_run++;
                    if (a_addr != a_hold_addr || a_wdata != a_hold_data) a_unstable++;
                end
                if (a_we_run > a_max_we_run) a_max_we_run = a_we_run;
                if (a_sck || a_cs_n) a_unstable++;
                if (a_ready) begin
                    if (a_wr_total == 0) a_first_addr = a_addr;
                    a_wr_total++;
                    if (a_addr < 4'd4) begin
                        a_mem[int'(a_addr)] = a_wdata;
                        a_wr[int'(a_addr)]++;
                    end
                end
            end
        end
        a_sck_q = a_sck; a_cs_q = a_cs_n; a_we_q = a_we;
    end

    // ---------------- instance B: flash returns 0xA0, 0xA1, ...
    int          b_fr, b_busy_cyc, b_wr_total, b_k;
    logic [31:0] b_cmd, b_mem0;
    logic [1:0]  b_first_addr;
    logic        b_first_mosi, b_sck_q, b_cs_q;
    logic [7:0]  b_bv;

    always @(negedge clk) begin
        if (mon_clr) begin
            b_fr = 0; b_busy_cyc = 0; b_wr_total = 0; b_cmd = 0;
            b_mem0 = 32'hDEADBEEF; b_first_addr = 2'b11; b_first_mosi = 1'b1;
        end else begin
            if (b_cs_n) begin
                b_fr = 0; b_miso = 1'b0;
            end else begin
                if (b_cs_q) b_first_mosi = b_mosi;
                if (b_sck && !b_sck_q) begin
                    if (b_fr < 32) b_cmd = {b_cmd[30:0], b_mosi};
                    b_fr++;
                end
                if (!b_sck && b_sck_q && b_fr >= 32) begin
                    b_k    = b_fr - 32;
                    b_bv   = 8'hA0 + 8'(b_k / 8);
                    b_miso = b_bv[7 - (b_k % 8)];
                end
            end
            if (b_busy) b_busy_cyc++;
            if (b_we && b_ready) begin
                if (b_wr_total == 0) b_first_addr = b_addr;
                if (b_addr == 2'd0) b_mem0 = b_wdata;
                b_wr_total++;
            end
        end
        b_sck_q = b_sck; b_cs_q = b_cs_n;
    end

    // Image word w when the flash streams bytes off, off+1, ...
    function automatic logic [31:0] exp_word(input int w, input logic [7:0] off);
        logic [7:0] b0;
        b0 = off + 8'(4 * w);
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_a;
        @(posedge clk);
        #1 a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic wait_a_done(input int budget);
        int n;
        n = 0;
        while (!a_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (a_done !== 1'b1) begin
            errors++;
            $display("FAIL a_done_timeout got done=%0b busy=%0b want done=1", a_done, a_busy);
        end
    endtask

    task automatic check_image(input string tag, input logic [7:0] off);
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (a_mem[w] !== exp_word(w, off) || a_wr[w] != 1) begin
                errors++;
                $display("FAIL %s word%0d got %08h (writes %0d) want %08h (writes 1)",
                         tag, w, a_mem[w], a_wr[w], exp_word(w, off));
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        a_off = 8'h00; mon_clr = 1'b1;
        #2;
        checks++;
        if ({a_sck, a_cs_n, a_mosi, a_we, a_core_rst, a_busy, a_done} !== 7'b0100100) begin
            errors++;
            $display("FAIL reset_ctrl got sck,cs_n,mosi,we,core_rst,busy,done=%b want 0100100",
                     {a_sck, a_cs_n, a_mosi, a_we, a_core_rst, a_busy, a_done});
        end
        checks++;
        if (a_addr !== 4'd0 || a_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_tcm got addr=%0h wdata=%08h want 0/0", a_addr, a_wdata);
        end
        checks++;
        if (b_cs_n !== 1'b1 || b_core_rst !== 1'b1 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_b got cs_n=%0b core_rst=%0b done=%0b want 1/1/0", b_cs_n, b_core_rst, b_done);
        end
        tick();
        tick();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_basic_load;
        clear_mon();
        a_off = 8'h00;
        pulse_a();
        wait_a_done(3000);
        checks++;
        if (a_cmd !== 32'h03000000) begin
            errors++; $display("FAIL basic_cmd got %08h want 03000000", a_cmd);
        end
        checks++;
        if (a_mem[0] !== 32'h03020100 || a_mem[1] !== 32'h07060504 ||
            a_mem[2] !== 32'h0B0A0908 || a_mem[3] !== 32'h0F0E0D0C) begin
            errors++;
            $display("FAIL basic_image got %08h %08h %08h %08h want 03020100 07060504 0B0A0908 0F0E0D0C",
                     a_mem[0], a_mem[1], a_mem[2], a_mem[3]);
        end
        checks++;
        if (a_rises != 160) begin
            errors++; $display("FAIL basic_sck_rises got %0d want 160", a_rises);
        end
        checks++;
        if (a_core_rst !== 1'b0 || a_busy !== 1'b0 || a_cs_n !== 1'b1 || a_rst_bad != 0) begin
            errors++;
            $display("FAIL basic_release got core_rst=%0b busy=%0b cs_n=%0b bad=%0d want 0/0/1/0",
                     a_core_rst, a_busy, a_cs_n, a_rst_bad);
        end
        checks++;
        if (a_busy_cyc != 644 || a_wr_total != 4) begin
            errors++;
            $display("FAIL basic_duration got busy=%0d writes=%0d want 644/4", a_busy_cyc, a_wr_total);
        end
    endtask

    task automatic test_sck_timing;
        clear_mon();
        a_off = 8'h10;
        pulse_a();
        wait_a_done(3000);
        checks++;
        if (a_hi_min != 2 || a_hi_max != 2 || a_lo_min != 2 || a_lo_max != 2) begin
            errors++;
            $display("FAIL sck_phase got hi %0d..%0d lo %0d..%0d want 2..2 2..2",
                     a_hi_min, a_hi_max, a_lo_min, a_lo_max);
        end
        checks++;
        if (a_cmd_cyc != 128) begin
            errors++; $display("FAIL cmd_cycles got %0d want 128", a_cmd_cyc);
        end
        checks++;
        if (a_first_mosi !== 1'b0 || a_cmd !== 32'h03000000) begin
            errors++;
            $display("FAIL first_mosi got %0b cmd=%08h want 0 03000000", a_first_mosi, a_cmd);
        end
        check_image("sck_image", 8'h10);
    endtask

    task automatic test_backpressure;
        int n;
        clear_mon();
        a_off = 8'h20;
        pulse_a();
        n = 0;
        while (!(a_addr == 4'd1 && !a_we) && n < 2000) begin @(negedge clk); n++; end
        a_ready = 1'b0;
        n = 0;
        while (!a_we && n < 2000) begin @(negedge clk); n++; end
        repeat (5) @(posedge clk);
        #1 a_ready = 1'b1;
        wait_a_done(3000);
        checks++;
        if (a_max_we_run != 6 || a_unstable != 0) begin
            errors++;
            $display("FAIL bp_hold got we_cycles=%0d unstable=%0d want 6/0", a_max_we_run, a_unstable);
        end
        checks++;
        if (a_wr[1] != 1 || a_mem[1] !== 32'h27262524) begin
            errors++;
            $display("FAIL bp_word1 got %08h writes=%0d want 27262524 writes=1", a_mem[1], a_wr[1]);
        end
        checks++;
        if (a_busy_cyc != 649 || a_wr_total != 4) begin
            errors++;
            $display("FAIL bp_duration got busy=%0d writes=%0d want 649/4", a_busy_cyc, a_wr_total);
        end
    endtask

    task automatic test_async_reset;
        int n;
        clear_mon();
        a_off = 8'h50;
        pulse_a();
        n = 0;
        while (!(a_addr == 4'd2 && !a_we) && n < 2000) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        n = 0;
        while (a_sck && n < 20) begin @(negedge clk); n++; end
        while (!a_sck && n < 40) begin @(negedge clk); n++; end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (a_cs_n !== 1'b1 || a_sck !== 1'b0 || a_core_rst !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_abort got cs_n=%0b sck=%0b core_rst=%0b busy=%0b want 1/0/1/0",
                     a_cs_n, a_sck, a_core_rst, a_busy);
        end
        checks++;
        if (a_we !== 1'b0 || a_done !== 1'b0 || a_mosi !== 1'b0 || a_addr !== 4'd0) begin
            errors++;
            $display("FAIL async_outputs got we=%0b done=%0b mosi=%0b addr=%0h want 0/0/0/0",
                     a_we, a_done, a_mosi, a_addr);
        end
        tick();
        tick();
        rst = 1'b0;
        clear_mon();
        a_off = 8'h60;
        pulse_a();
        wait_a_done(3000);
        checks++;
        if (a_cmd !== 32'h03000000 || a_first_addr !== 4'd0 || a_wr_total != 4) begin
            errors++;
            $display("FAIL async_reload got cmd=%08h first_addr=%0h writes=%0d want 03000000/0/4",
                     a_cmd, a_first_addr, a_wr_total);
        end
        check_image("async_image", 8'h60);
    endtask

    task automatic test_start_while_busy;
        clear_mon();
        a_off = 8'h70;
        pulse_a();
        repeat (300) @(negedge clk);
        pulse_a();
        wait_a_done(3000);
        checks++;
        if (a_busy_cyc != 644 || a_rises != 160 || a_wr_total != 4) begin
            errors++;
            $display("FAIL busy_start got busy=%0d rises=%0d writes=%0d want 644/160/4",
                     a_busy_cyc, a_rises, a_wr_total);
        end
        check_image("busy_image", 8'h70);
    endtask

    task automatic test_reload_from_done;
        clear_mon();
        a_off = 8'h90;
        pulse_a();
        checks++;
        if (a_core_rst !== 1'b1 || a_done !== 1'b0 || a_busy !== 1'b1 || a_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL reload_entry got core_rst=%0b done=%0b busy=%0b cs_n=%0b want 1/0/1/0",
                     a_core_rst, a_done, a_busy, a_cs_n);
        end
        wait_a_done(3000);
        checks++;
        if (a_cmd !== 32'h03000000 || a_wr_total != 4 || a_mem[3] !== 32'h9F9E9D9C) begin
            errors++;
            $display("FAIL reload_done got cmd=%08h writes=%0d word3=%08h want 03000000/4/9F9E9D9C",
                     a_cmd, a_wr_total, a_mem[3]);
        end
        check_image("reload_image", 8'h90);
    endtask

    task automatic test_flash_base;
        int n;
        clear_mon();
        checks++;
        if (b_core_rst !== 1'b1 || b_done !== 1'b0) begin
            errors++; $display("FAIL base_idle got core_rst=%0b done=%0b want 1/0", b_core_rst, b_done);
        end
        @(posedge clk);
        #1 b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        while (!b_done && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (b_done !== 1'b1 || b_core_rst !== 1'b0) begin
            errors++; $display("FAIL base_done got done=%0b core_rst=%0b want 1/0", b_done, b_core_rst);
        end
        checks++;
        if (b_cmd !== 32'h03012340 || b_first_mosi !== 1'b0) begin
            errors++;
            $display("FAIL base_cmd got %08h first_mosi=%0b want 03012340 0", b_cmd, b_first_mosi);
        end
        checks++;
        if (b_wr_total != 1 || b_first_addr !== 2'd0 || b_mem0 !== 32'hA3A2A1A0) begin
            errors++;
            $display("FAIL base_write got writes=%0d addr=%0h data=%08h want 1/0/A3A2A1A0",
                     b_wr_total, b_first_addr, b_mem0);
        end
        checks++;
        if (b_busy_cyc != 257) begin
            errors++; $display("FAIL base_duration got %0d want 257", b_busy_cyc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_load();
        test_sck_timing();
        test_backpressure();
        test_async_reset();
        test_start_while_busy();
        test_reload_from_done();
        test_flash_base();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcm_boot_loader.md
Name: tcm_boot_loader

Overview:
- Boot controller for the MCU: on start, reads a program image from external SPI NOR flash (READ 0x03, SPI mode 0) and writes it word by word into the SCR1 TCM through a simple write port.
- Holds the SCR1 core in reset until the image is fully loaded, then releases it.
- Replaces file-based TCM preload on silicon/FPGA; sits between the pad-level SPI pins, the TCM write mux and the core reset input.

Parameters:
TCM_AW, 14, TCM word-address width (words, not bytes)
BOOT_WORDS, 1024, number of 32-bit words to load; 1..2**TCM_AW
FLASH_BASE, 24'h000000, flash byte address of the image
SCK_DIV, 2, SCK half-period in clk_i cycles; >=1

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  single-cycle load request
spi_sck_o  out  1  flash SPI clock, idle low
spi_cs_n_o  out  1  flash chip select, active low
spi_mosi_o  out  1  command/address to flash
spi_miso_i  in  1  data from flash
tcm_we_o  out  1  TCM write request
tcm_addr_o  out  TCM_AW  TCM word address
tcm_wdata_o  out  32  TCM write data
tcm_ready_i  in  1  TCM write accepted this cycle
core_rst_o  out  1  core reset, active high
busy_o  out  1  load in progress
done_o  out  1  image loaded (sticky)

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: sck 0, cs_n 1, mosi 0, tcm_we 0, tcm_addr 0, tcm_wdata 0, core_rst 1, busy 0, done 0; FSM in IDLE, word counter 0.
- rst_i mid-load: all outputs return to reset values immediately. cs_n rises asynchronously, aborting the flash transfer.
- FSM states: IDLE, CMD, DATA, WRITE, DONE.
- IDLE:
  - start_i=1 -> next cycle CMD, cs_n=0, busy=1, core_rst=1, done=0.
  - mosi immediately carries bit 31 of the command word {8'h03, FLASH_BASE}.
- SCK generation (CMD and DATA):
  - Divider counter counts 0..SCK_DIV-1; SCK toggles on wrap.
  - Each bit is SCK_DIV cycles low, then SCK_DIV cycles high.
  - On the low->high clk edge, miso is sampled into the shift register.
  - On the high->low edge, mosi shifts to the next bit, MSB first.
  - One SCK period is 2*SCK_DIV clocks.
- CMD: 32 bits. After the 32nd high phase ends (SCK low), go to DATA; mosi=0 from then on.
- DATA:
  - 32 bits received, assembled little-endian: 1st flash byte -> wdata[7:0], 4th -> [31:24]; each byte MSB first.
  - After the 32nd high phase ends, go to WRITE.
- WRITE:
  - tcm_we=1; addr = word counter; wdata = assembled word. All held stable until tcm_ready_i=1 is sampled.
  - SCK held low and cs_n held low (continuous read; flash streams on resume).
  - Accept cycle, not last word: tcm_we=0 next cycle, counter+1, return to DATA.
  - Accept cycle, word counter = BOOT_WORDS-1: go to DONE.
- DONE: cs_n=1, busy=0, done=1, core_rst=0, all from the same cycle. tcm_we=0.
- start_i while busy: ignored.
- start_i in DONE: reload. Takes the IDLE path: core_rst=1, done=0, counter=0.
- Counter width is TCM_AW; it never wraps because the load terminates at BOOT_WORDS-1.
- Total flash SCK periods per load: 32 + 32*BOOT_WORDS.
- Minimum load time: (32+32*BOOT_WORDS)*2*SCK_DIV clocks, plus one clock per word for the WRITE accept with zero-wait TCM.

Test Plan:
1. Basic load: BOOT_WORDS=4, SCK_DIV=2, flash model returns bytes 0x00,0x01,...
   -> TCM words 0..3 = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
   -> Captured MOSI command = 0x03000000.
   -> core_rst_o falls with done_o=1; exactly 160 SCK rising edges.
2. SCK timing: SCK_DIV=2.
   -> SCK high/low each exactly 2 clk cycles.
   -> First MOSI bit valid when cs_n falls.
   -> MISO sampled only on SCK rising.
   -> Command phase lasts 128 clocks.
3. TCM backpressure: tcm_ready_i held low 5 cycles on word 1.
   -> tcm_we/addr=1/wdata stable for all 6 cycles; SCK stays low, cs_n stays low.
   -> Word 1 written once only.
4. Async reset mid-DATA at word 2.
   -> cs_n=1, sck=0, core_rst=1, busy=0 without waiting for a clock edge.
   -> A following start_i reloads from word 0 with the correct command.
5. start_i pulsed while busy -> no restart; the load completes normally.
   start_i in DONE -> core_rst_o reasserts next cycle and a full reload occurs.
6. FLASH_BASE=24'h012340, BOOT_WORDS=1 -> MOSI command 0x03012340; a single WRITE to addr 0; then DONE.
